// File: rtl/kplic_pkg.sv
// Shared KPLIC sizing constants used by the arbitration core and its priority tree.
package kplic_pkg;

    localparam int KPLIC_NUM_SRC   = 31;
    localparam int KPLIC_PRIO_W    = 3;
    localparam int KPLIC_ID_W      = 5;
    localparam int KPLIC_NO_INT_ID = 0;

endpackage

// File: rtl/kplic_prio_arb.sv
// Combinational max-priority selector: highest priority wins, ties go to the lowest ID,
// priority 0 never wins. Reports ID 0 / priority 0 when there is no candidate.
module kplic_prio_arb
    import kplic_pkg::*;
#(
    parameter int NUM_SRC = KPLIC_NUM_SRC,
    parameter int PRIO_W  = KPLIC_PRIO_W,
    parameter int ID_W    = KPLIC_ID_W
) (
    input  logic [NUM_SRC-1:0]        cand_i,
    input  logic [NUM_SRC*PRIO_W-1:0] prio_i,
    output logic [ID_W-1:0]           win_id_o,
    output logic [PRIO_W-1:0]         win_prio_o
);

    logic [PRIO_W-1:0] prio_a [NUM_SRC];
    logic [ID_W-1:0]   id_v;
    logic [PRIO_W-1:0] prio_v;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_prio
        assign prio_a[gi] = cand_i[gi] ? prio_i[gi*PRIO_W +: PRIO_W] : '0;
    end

    // Scanning from the highest ID down with >= lets the lowest ID take equal priorities.
    always_comb begin
        id_v   = '0;
        prio_v = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (prio_a[i] != '0 && prio_a[i] >= prio_v) begin
                id_v   = ID_W'(i + 1);
                prio_v = prio_a[i];
            end
        end
    end

    assign win_id_o   = id_v;
    assign win_prio_o = prio_v;

endmodule

// File: rtl/kplic_core.sv
// KPLIC arbitration core: pending/in-service tracking, registered winner selection,
// hart interrupt generation and claim/complete handshakes with one-hot completion pulses.
module kplic_core
    import kplic_pkg::*;
#(
    parameter int NUM_SRC = KPLIC_NUM_SRC,
    parameter int PRIO_W  = KPLIC_PRIO_W,
    parameter int ID_W    = KPLIC_ID_W
) (
    input  logic                      kplic_clk,
    input  logic                      kplic_rst,
    input  logic [NUM_SRC-1:0]        valid_int_req,
    input  logic [NUM_SRC*PRIO_W-1:0] int_priority,
    input  logic [PRIO_W-1:0]         int_threshold,
    input  logic                      claim_req,
    output logic [ID_W-1:0]           claim_id,
    input  logic                      complete_req,
    input  logic [ID_W-1:0]           complete_id,
    output logic [NUM_SRC-1:0]        int_completion,
    output logic [NUM_SRC-1:0]        int_pending,
    output logic                      kplic_int
);

    logic [NUM_SRC-1:0] pending_q, pending_d;
    logic [NUM_SRC-1:0] in_service_q, in_service_d;
    logic [NUM_SRC-1:0] completion_q;
    logic [ID_W-1:0]    best_id_q, claim_id_q, claim_id_d;
    logic [PRIO_W-1:0]  best_prio_q, thr_q;
    logic               claim_blank_q, int_q, int_d;

    logic               claim_ok;
    logic [NUM_SRC-1:0] clr_mask, cmp_mask, cand;
    logic [ID_W-1:0]    arb_id;
    logic [PRIO_W-1:0]  arb_prio;

    assign claim_ok = claim_req && int_q && !claim_blank_q && (best_id_q != '0);

    // Per-source decode of the claimed and completed IDs; IDs outside 1..NUM_SRC match nothing.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign clr_mask[gi] = claim_ok && (best_id_q == ID_W'(gi + 1));
        assign cmp_mask[gi] = complete_req && (complete_id == ID_W'(gi + 1)) && in_service_q[gi];
    end

    // The source being claimed is already excluded from this cycle's arbitration,
    // so the next winner is ready as soon as the claim blanking window ends.
    assign cand = pending_q & ~clr_mask;

    kplic_prio_arb #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_arb (
        .cand_i     (cand),
        .prio_i     (int_priority),
        .win_id_o   (arb_id),
        .win_prio_o (arb_prio)
    );

    always_comb begin
        pending_d    = cand | valid_int_req;
        in_service_d = (in_service_q & ~cmp_mask) | clr_mask;
        int_d        = (best_prio_q > thr_q) && !claim_ok;
        claim_id_d   = claim_id_q;
        if (claim_req) begin
            claim_id_d = claim_ok ? best_id_q : ID_W'(KPLIC_NO_INT_ID);
        end
    end

    always_ff @(posedge kplic_clk or posedge kplic_rst) begin
        if (kplic_rst) begin
            pending_q     <= '0;
            in_service_q  <= '0;
            completion_q  <= '0;
            best_id_q     <= '0;
            best_prio_q   <= '0;
            thr_q         <= '0;
            claim_blank_q <= 1'b0;
            int_q         <= 1'b0;
            claim_id_q    <= '0;
        end else begin
            pending_q     <= pending_d;
            in_service_q  <= in_service_d;
            completion_q  <= cmp_mask;
            best_id_q     <= arb_id;
            best_prio_q   <= arb_prio;
            thr_q         <= int_threshold;
            claim_blank_q <= claim_ok;
            int_q         <= int_d;
            claim_id_q    <= claim_id_d;
        end
    end

    assign claim_id       = claim_id_q;
    assign int_completion = completion_q;
    assign int_pending    = pending_q;
    assign kplic_int      = int_q;

endmodule

// File: tb/tb_kplic_core.sv
// Scoreboard bench for kplic_core: directed scenarios followed by randomized traffic,
// all checked against a source-level model of pending, in-service and arbitration rules.
module tb_kplic_core;

    localparam int NS = 20;
    localparam int PW = 3;
    localparam int IW = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NS-1:0]    vreq = '0;
    logic [NS*PW-1:0] prio_v = '0;
    logic [PW-1:0]    thr = '0;
    logic             claim_req = 1'b0;
    logic             complete_req = 1'b0;
    logic [IW-1:0]    complete_id = '0;
    logic [IW-1:0]    claim_id;
    logic [NS-1:0]    comp;
    logic [NS-1:0]    pend;
    logic             kint;

    always #5 clk = ~clk;

    kplic_core #(.NUM_SRC(NS), .PRIO_W(PW), .ID_W(IW)) dut (
        .kplic_clk      (clk),
        .kplic_rst      (rst),
        .valid_int_req  (vreq),
        .int_priority   (prio_v),
        .int_threshold  (thr),
        .claim_req      (claim_req),
        .claim_id       (claim_id),
        .complete_req   (complete_req),
        .complete_id    (complete_id),
        .int_completion (comp),
        .int_pending    (pend),
        .kplic_int      (kint)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state, indexed by source ID (index 0 unused).
    int m_prio  [NS+1];
    bit m_pend  [NS+1];
    bit m_insvc [NS+1];
    int m_thr = 0;

    int            claim_q [$];
    logic [NS-1:0] comp_q  [$];
    bit            claim_seen = 0;
    bit            comp_seen  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_winner();
        int w = 0;
        int bp = 0;
        for (int id = 1; id <= NS; id++)
            if (m_pend[id] && m_prio[id] > bp) begin
                w  = id;
                bp = m_prio[id];
            end
        return w;
    endfunction

    function automatic bit model_int();
        int w = model_winner();
        return (w != 0) && (m_prio[w] > m_thr);
    endfunction

    function automatic int model_claim();
        int w;
        if (!model_int()) return 0;
        w = model_winner();
        m_pend[w]  = 0;
        m_insvc[w] = 1;
        return w;
    endfunction

    function automatic logic [NS-1:0] model_complete(input int id);
        logic [NS-1:0] m = '0;
        if (id >= 1 && id <= NS && m_insvc[id]) begin
            m_insvc[id] = 0;
            m[id-1] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [NS-1:0] model_pend_vec();
        logic [NS-1:0] v = '0;
        for (int id = 1; id <= NS; id++) v[id-1] = m_pend[id];
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_pulse(input logic [NS-1:0] mask);
        @(negedge clk);
        vreq = mask;
        for (int id = 1; id <= NS; id++) if (mask[id-1]) m_pend[id] = 1;
        @(negedge clk);
        vreq = '0;
    endtask

    task automatic set_prio(input int id, input int p);
        prio_v[(id-1)*PW +: PW] = PW'(p);
        m_prio[id] = p;
    endtask

    task automatic set_thr(input int t);
        thr   = PW'(t);
        m_thr = t;
    endtask

    // Consecutive-cycle claims: a claim right after an accepted one lands in the blanking window.
    task automatic claim_burst(input int n);
        bit last_acc = 0;
        int r;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            claim_req = 1'b1;
            r = last_acc ? 0 : model_claim();
            last_acc = (r != 0);
            claim_q.push_back(r);
        end
        @(negedge clk);
        claim_req = 1'b0;
    endtask

    task automatic do_complete(input int id, input bit with_claim);
        @(negedge clk);
        complete_req = 1'b1;
        complete_id  = IW'(id);
        comp_q.push_back(model_complete(id));
        if (with_claim) begin
            claim_req = 1'b1;
            claim_q.push_back(model_claim());
        end
        @(negedge clk);
        complete_req = 1'b0;
        claim_req    = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_kplic_int"}, 64'(kint), 64'(model_int()));
        check({tag, "_int_pending"}, 64'(pend), 64'(model_pend_vec()));
    endtask

    always @(posedge clk) begin
        claim_seen <= claim_req;
        comp_seen  <= complete_req;
    end

    // Monitor: consumes one expectation per observed handshake, independent of the stimulus thread.
    always @(negedge clk) begin
        if (!rst) begin
            if (claim_seen) begin
                if (claim_q.size() == 0) check("claim_q_underflow", 64'd1, 64'd0);
                else                     check("claim_id", 64'(claim_id), 64'(claim_q.pop_front()));
            end
            if (comp_seen) begin
                if (comp_q.size() == 0) check("comp_q_underflow", 64'd1, 64'd0);
                else                    check("int_completion", 64'(comp), 64'(comp_q.pop_front()));
            end else begin
                check("no_stray_completion", 64'(comp), 64'd0);
            end
        end
    end

    initial begin
        for (int id = 0; id <= NS; id++) begin
            m_prio[id] = 0; m_pend[id] = 0; m_insvc[id] = 0;
        end
        tick(3);
        check("rst_int_pending", 64'(pend), 64'd0);
        check("rst_claim_id", 64'(claim_id), 64'd0);
        check("rst_int_completion", 64'(comp), 64'd0);
        check("rst_kplic_int", 64'(kint), 64'd0);
        rst = 1'b0;
        tick(2);

        // Single source: 3-cycle latency to kplic_int, then claim.
        set_thr(0);
        set_prio(3, 5);
        tick(2);
        do_pulse(NS'(1) << 2);
        check("single_pend_next_cycle", 64'(pend[2]), 64'd1);
        tick(1);
        check("single_int_c2", 64'(kint), 64'd0);
        tick(1);
        check("single_int_c3", 64'(kint), 64'(model_int()));
        claim_burst(1);
        check("single_int_after_claim", 64'(kint), 64'd0);
        check("single_pend_after_claim", 64'(pend[2]), 64'd0);

        // Max priority with lowest-ID tie break.
        set_prio(2, 4); set_prio(5, 6); set_prio(7, 6);
        do_pulse((NS'(1) << 1) | (NS'(1) << 4) | (NS'(1) << 6));
        tick(3);
        check_state("tie_settled");
        repeat (4) claim_burst(1);
        tick(2);
        check_state("tie_drained");

        // Completion and ignored completions.
        do_complete(5, 0);
        do_complete(5, 0);
        do_complete(0, 0);
        do_complete(31, 0);

        // Priority equal to threshold never interrupts; lowering threshold takes 2 cycles.
        set_thr(3);
        set_prio(4, 3);
        do_pulse(NS'(1) << 3);
        tick(3);
        check_state("thr_equal");
        claim_burst(1);
        @(negedge clk);
        set_thr(2);
        tick(1);
        check("thr_change_c1", 64'(kint), 64'd0);
        tick(1);
        check("thr_change_c2", 64'(kint), 64'(model_int()));
        claim_burst(1);

        // Back-to-back claims.
        set_thr(0);
        set_prio(9, 5); set_prio(10, 2);
        do_pulse((NS'(1) << 8) | (NS'(1) << 9));
        tick(3);
        claim_burst(3);

        // Same-cycle claim and complete of one ID re-arms it.
        do_pulse(NS'(1) << 8);
        tick(3);
        do_complete(9, 1);
        do_complete(9, 0);

        // Asynchronous reset mid-operation.
        set_prio(11, 1); set_prio(12, 3); set_prio(13, 7);
        do_pulse((NS'(7) << 10));
        tick(3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_int_pending", 64'(pend), 64'd0);
        check("arst_claim_id", 64'(claim_id), 64'd0);
        check("arst_kplic_int", 64'(kint), 64'd0);
        check("arst_int_completion", 64'(comp), 64'd0);
        for (int id = 0; id <= NS; id++) begin
            m_pend[id] = 0; m_insvc[id] = 0;
        end
        claim_q.delete();
        comp_q.delete();
        tick(2);
        rst = 1'b0;
        tick(2);
        do_complete(10, 0);
        tick(2);
        check_state("post_reset");

        // Randomized traffic.
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 5))
                0: begin
                    do_pulse(NS'($urandom) & NS'($urandom));
                    tick(3);
                end
                1: begin
                    @(negedge clk);
                    set_prio($urandom_range(1, NS), $urandom_range(0, 7));
                    tick(2);
                end
                2: begin
                    @(negedge clk);
                    set_thr($urandom_range(0, 3));
                    tick(2);
                end
                3: claim_burst($urandom_range(1, 3));
                4: do_complete($urandom_range(0, 31), bit'($urandom_range(0, 1)));
                default: begin
                    tick(2);
                    check_state("rand");
                end
            endcase
        end

        tick(3);
        check("claim_q_drained", 64'(claim_q.size()), 64'd0);
        check("comp_q_drained", 64'(comp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
